// File: rtl/time_entry_loader.sv
// Keypad entry of an M:SS preset, replayed serially onto the counter load bus on start.
// Optional idle-entry auto-clear is enabled by defining ENTRY_TIMEOUT_EN.
module time_entry_loader #(
    parameter int unsigned MAX_SEC_TENS   = 5,
    parameter int unsigned TIMEOUT_CYCLES = 1000
) (
    input  logic       clock,
    input  logic       clr,
    input  logic       key_valid,
    input  logic [3:0] key_digit,
    input  logic       clear_key,
    input  logic       start_key,
    input  logic       counter_busy,
    output logic [3:0] data,
    output logic       loadn,
    output logic       start_pulse,
    output logic [3:0] mins,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       entry_err
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_ENTRY  = 3'd1;
    localparam logic [2:0] ST_LOAD_M = 3'd2;
    localparam logic [2:0] ST_LOAD_T = 3'd3;
    localparam logic [2:0] ST_LOAD_O = 3'd4;
    localparam logic [2:0] ST_DONE   = 3'd5;

    localparam logic [3:0] MAX_TENS = 4'(MAX_SEC_TENS);

    logic [2:0] state_q, state_d;
    logic [3:0] mins_q, mins_d;
    logic [3:0] sec_tens_q, sec_tens_d;
    logic [3:0] sec_ones_q, sec_ones_d;
    logic [3:0] data_q, data_d;
    logic       loadn_q, loadn_d;
    logic       start_pulse_q, start_pulse_d;
    logic       entry_err_q, entry_err_d;
    logic       timeout_hit;

`ifdef ENTRY_TIMEOUT_EN
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CNT_W-1:0] idle_cnt_q, idle_cnt_d;
    logic             any_key;

    // Counts quiet cycles spent in ENTRY; any strobe restarts it.
    always_comb begin
        any_key     = key_valid | start_key | clear_key;
        timeout_hit = (state_q == ST_ENTRY) && !any_key &&
                      (idle_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
        if ((state_q != ST_ENTRY) || any_key || timeout_hit) begin
            idle_cnt_d = '0;
        end else begin
            idle_cnt_d = idle_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (clr) begin
            idle_cnt_q <= '0;
        end else begin
            idle_cnt_q <= idle_cnt_d;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        mins_d        = mins_q;
        sec_tens_d    = sec_tens_q;
        sec_ones_d    = sec_ones_q;
        entry_err_d   = entry_err_q;
        data_d        = 4'd0;
        loadn_d       = 1'b1;
        start_pulse_d = 1'b0;

        case (state_q)
            ST_IDLE, ST_ENTRY: begin
                if (clear_key || timeout_hit) begin
                    state_d     = ST_IDLE;
                    mins_d      = 4'd0;
                    sec_tens_d  = 4'd0;
                    sec_ones_d  = 4'd0;
                    entry_err_d = 1'b0;
                end else if (counter_busy) begin
                    state_d = state_q;
                end else if (start_key) begin
                    if (state_q == ST_ENTRY) begin
                        if (sec_tens_q > MAX_TENS) begin
                            entry_err_d = 1'b1;
                        end else if ({mins_q, sec_tens_q, sec_ones_q} != 12'd0) begin
                            state_d = ST_LOAD_M;
                            data_d  = mins_q;
                            loadn_d = 1'b0;
                        end
                    end
                end else if (key_valid) begin
                    if (key_digit <= 4'd9) begin
                        mins_d      = sec_tens_q;
                        sec_tens_d  = sec_ones_q;
                        sec_ones_d  = key_digit;
                        entry_err_d = 1'b0;
                        state_d     = ST_ENTRY;
                    end else begin
                        entry_err_d = 1'b1;
                    end
                end
            end
            ST_LOAD_M, ST_LOAD_T, ST_LOAD_O: begin
                if (clear_key) begin
                    state_d     = ST_IDLE;
                    mins_d      = 4'd0;
                    sec_tens_d  = 4'd0;
                    sec_ones_d  = 4'd0;
                    entry_err_d = 1'b0;
                end else if (state_q == ST_LOAD_M) begin
                    state_d = ST_LOAD_T;
                    data_d  = sec_tens_q;
                    loadn_d = 1'b0;
                end else if (state_q == ST_LOAD_T) begin
                    state_d = ST_LOAD_O;
                    data_d  = sec_ones_q;
                    loadn_d = 1'b0;
                end else begin
                    state_d       = ST_DONE;
                    start_pulse_d = 1'b1;
                end
            end
            ST_DONE: begin
                // Start is already committed here, so clear_key has nothing to cancel.
                state_d    = ST_IDLE;
                mins_d     = 4'd0;
                sec_tens_d = 4'd0;
                sec_ones_d = 4'd0;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (clr) begin
            state_q       <= ST_IDLE;
            mins_q        <= 4'd0;
            sec_tens_q    <= 4'd0;
            sec_ones_q    <= 4'd0;
            data_q        <= 4'd0;
            loadn_q       <= 1'b1;
            start_pulse_q <= 1'b0;
            entry_err_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            mins_q        <= mins_d;
            sec_tens_q    <= sec_tens_d;
            sec_ones_q    <= sec_ones_d;
            data_q        <= data_d;
            loadn_q       <= loadn_d;
            start_pulse_q <= start_pulse_d;
            entry_err_q   <= entry_err_d;
        end
    end

    assign data        = data_q;
    assign loadn       = loadn_q;
    assign start_pulse = start_pulse_q;
    assign mins        = mins_q;
    assign sec_tens    = sec_tens_q;
    assign sec_ones    = sec_ones_q;
    assign entry_err   = entry_err_q;

endmodule

// File: tb/tb_time_entry_loader.sv
// Bench for time_entry_loader: directed scenarios plus random keystrokes against a
// preset-as-integer reference model.
module tb_time_entry_loader;

    localparam int MAX_TENS = 5;
    localparam int TMO      = 8;
`ifdef ENTRY_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       clr = 1'b0;
    logic       key_valid = 1'b0;
    logic [3:0] key_digit = 4'd0;
    logic       clear_key = 1'b0;
    logic       start_key = 1'b0;
    logic       counter_busy = 1'b0;
    logic [3:0] data;
    logic       loadn;
    logic       start_pulse;
    logic [3:0] mins;
    logic [3:0] sec_tens;
    logic [3:0] sec_ones;
    logic       entry_err;

    int vectors = 0;
    int miscompares = 0;

    // Model: preset held as a decimal integer 0..999, plus load progress 0 (none) .. 4 (pulse).
    int m_preset = 0;
    bit m_has = 1'b0;
    int m_step = 0;
    bit m_err = 1'b0;
    int m_quiet = 0;

    time_entry_loader #(
        .MAX_SEC_TENS  (MAX_TENS),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clock       (clock),
        .clr         (clr),
        .key_valid   (key_valid),
        .key_digit   (key_digit),
        .clear_key   (clear_key),
        .start_key   (start_key),
        .counter_busy(counter_busy),
        .data        (data),
        .loadn       (loadn),
        .start_pulse (start_pulse),
        .mins        (mins),
        .sec_tens    (sec_tens),
        .sec_ones    (sec_ones),
        .entry_err   (entry_err)
    );

    always #5 clock = ~clock;

    wire [18:0] obs = {data, loadn, start_pulse, mins, sec_tens, sec_ones, entry_err};
    wire [11:0] preview = {mins, sec_tens, sec_ones};

    task automatic model_clear();
        m_preset = 0;
        m_has    = 1'b0;
        m_step   = 0;
        m_err    = 1'b0;
        m_quiet  = 0;
    endtask

    task automatic model_update();
        bit any;
        any = key_valid | start_key | clear_key;
        if (clr) begin
            model_clear();
        end else if (m_step >= 1 && m_step <= 3) begin
            m_quiet = 0;
            if (clear_key) model_clear();
            else m_step++;
        end else if (m_step == 4) begin
            m_quiet  = 0;
            m_step   = 0;
            m_preset = 0;
            m_has    = 1'b0;
        end else begin
            if (m_has && !any) m_quiet++;
            else m_quiet = 0;
            if (clear_key || (TMO_EN && m_quiet == TMO)) begin
                model_clear();
            end else if (counter_busy) begin
                m_step = 0;
            end else if (start_key) begin
                if (m_has) begin
                    if ((m_preset / 10) % 10 > MAX_TENS) m_err = 1'b1;
                    else if (m_preset != 0) m_step = 1;
                end
            end else if (key_valid) begin
                if (key_digit <= 9) begin
                    m_preset = (m_preset * 10 + int'(key_digit)) % 1000;
                    m_err    = 1'b0;
                    m_has    = 1'b1;
                end else begin
                    m_err = 1'b1;
                end
            end
        end
    endtask

    function automatic logic [18:0] exp_vec();
        logic [3:0] m, t, o, d;
        m = 4'(m_preset / 100);
        t = 4'((m_preset / 10) % 10);
        o = 4'(m_preset % 10);
        d = (m_step == 1) ? m : (m_step == 2) ? t : (m_step == 3) ? o : 4'd0;
        return {d, !(m_step >= 1 && m_step <= 3), (m_step == 4), m, t, o, m_err};
    endfunction

    // Drive one cycle's inputs, advance an edge, update the model, settle away from the edge.
    task automatic step(input bit c, input bit kv, input logic [3:0] kd, input bit ck,
                        input bit sk, input bit busy);
        clr          = c;
        key_valid    = kv;
        key_digit    = kd;
        clear_key    = ck;
        start_key    = sk;
        counter_busy = busy;
        @(posedge clock);
        model_update();
        #1;
        clr       = 1'b0;
        key_valid = 1'b0;
        clear_key = 1'b0;
        start_key = 1'b0;
    endtask

    task automatic test_reset();
        step(1, 0, 0, 0, 0, 0);
        vectors++;
        if (obs !== {4'h0, 1'b1, 1'b0, 12'h000, 1'b0}) begin
            miscompares++;
            $display("FAIL reset: got %h want %h", obs, {4'h0, 1'b1, 1'b0, 12'h000, 1'b0});
        end
    endtask

    task automatic test_load_sequence();
        logic [5:0] seq [5];
        logic [3:0] keys [3];
        seq  = '{6'b0001_0_0, 6'b0011_0_0, 6'b0000_0_0, 6'b0000_1_1, 6'b0000_1_0};
        keys = '{4'd1, 4'd3, 4'd0};
        foreach (keys[i]) step(0, 1, keys[i], 0, 0, 0);
        vectors++;
        if (preview !== 12'h130) begin
            miscompares++;
            $display("FAIL entry_130: got %h want 130", preview);
        end
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 0, 0, (i == 0), 0);
            vectors++;
            if ({data, loadn, start_pulse} !== seq[i] || obs !== exp_vec()) begin
                miscompares++;
                $display("FAIL load_seq[%0d]: got %h want %h (model %h)", i,
                         {data, loadn, start_pulse}, seq[i], exp_vec());
            end
        end
        vectors++;
        if (preview !== 12'h000) begin
            miscompares++;
            $display("FAIL load_cleared: got %h want 000", preview);
        end
    endtask

    task automatic test_shift_invalid();
        for (int d = 1; d <= 4; d++) step(0, 1, 4'(d), 0, 0, 0);
        vectors++;
        if (preview !== 12'h234 || entry_err !== 1'b0) begin
            miscompares++;
            $display("FAIL shift_234: got %h err %b want 234 err 0", preview, entry_err);
        end
        step(0, 1, 4'hA, 0, 0, 0);
        vectors++;
        if (preview !== 12'h234 || entry_err !== 1'b1) begin
            miscompares++;
            $display("FAIL bad_digit: got %h err %b want 234 err 1", preview, entry_err);
        end
        step(0, 0, 0, 1, 0, 0);
        vectors++;
        if (obs !== exp_vec()) begin
            miscompares++;
            $display("FAIL shift_clear: got %h want %h", obs, exp_vec());
        end
    endtask

    task automatic test_bad_start();
        step(0, 1, 4'd1, 0, 0, 0);
        step(0, 1, 4'd7, 0, 0, 0);
        step(0, 1, 4'd0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0);
        vectors++;
        if (entry_err !== 1'b1 || loadn !== 1'b1 || preview !== 12'h170) begin
            miscompares++;
            $display("FAIL bad_start: got err %b loadn %b %h want 1 1 170",
                     entry_err, loadn, preview);
        end
        step(0, 0, 0, 0, 0, 0);
        vectors++;
        if (loadn !== 1'b1 || obs !== exp_vec()) begin
            miscompares++;
            $display("FAIL bad_start_hold: got %h want %h", obs, exp_vec());
        end
        step(0, 0, 0, 1, 0, 0);
        vectors++;
        if (preview !== 12'h000 || entry_err !== 1'b0) begin
            miscompares++;
            $display("FAIL bad_start_clear: got %h err %b want 000 err 0", preview, entry_err);
        end
    endtask

    task automatic test_zero_and_busy();
        step(0, 1, 4'd0, 0, 0, 0);
        step(0, 1, 4'd0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (loadn !== 1'b1 || start_pulse !== 1'b0 || obs !== exp_vec()) begin
                miscompares++;
                $display("FAIL zero_start[%0d]: got %h want %h", i, obs, exp_vec());
            end
            step(0, 0, 0, 0, 0, 0);
        end
        step(0, 1, 4'd2, 0, 0, 0);
        step(0, 1, 4'd5, 0, 0, 1);
        vectors++;
        if (preview !== 12'h002) begin
            miscompares++;
            $display("FAIL busy_key: got %h want 002", preview);
        end
        step(0, 0, 0, 0, 1, 1);
        vectors++;
        if (loadn !== 1'b1 || obs !== exp_vec()) begin
            miscompares++;
            $display("FAIL busy_start: got %h want %h", obs, exp_vec());
        end
        step(0, 0, 0, 1, 0, 1);
        vectors++;
        if (preview !== 12'h000) begin
            miscompares++;
            $display("FAIL busy_clear: got %h want 000", preview);
        end
    endtask

    task automatic test_abort();
        for (int r = 0; r < 2; r++) begin
            step(0, 1, 4'd9, 0, 0, 0);
            step(0, 1, 4'd5, 0, 0, 0);
            step(0, 1, 4'd9, 0, 0, 0);
            step(0, 0, 0, 0, 1, 0);
            if (r == 0) begin
                step(0, 0, 0, 0, 0, 0);
                step(0, 0, 0, 1, 0, 0);
            end else begin
                step(1, 0, 0, 0, 0, 0);
            end
            for (int i = 0; i < 4; i++) begin
                vectors++;
                if (loadn !== 1'b1 || start_pulse !== 1'b0 || preview !== 12'h000 ||
                    obs !== exp_vec()) begin
                    miscompares++;
                    $display("FAIL abort%0d[%0d]: got %h want %h", r, i, obs, exp_vec());
                end
                step(0, 0, 0, 0, 0, 0);
            end
        end
    endtask

    task automatic test_timeout();
        step(0, 1, 4'd4, 0, 0, 0);
        for (int i = 0; i < TMO - 2; i++) step(0, 0, 0, 0, 0, 0);
        step(0, 1, 4'd1, 0, 0, 0);
        for (int i = 0; i < TMO - 1; i++) step(0, 0, 0, 0, 0, 0);
        vectors++;
        if (preview !== 12'h041) begin
            miscompares++;
            $display("FAIL timeout_restart: got %h want 041", preview);
        end
        step(0, 0, 0, 0, 0, 0);
        vectors++;
        if (preview !== (TMO_EN ? 12'h000 : 12'h041) || obs !== exp_vec()) begin
            miscompares++;
            $display("FAIL timeout_expire: got %h want %h", obs, exp_vec());
        end
        for (int i = 0; i < 20; i++) step(0, 0, 0, 0, 0, 0);
        vectors++;
        if (preview !== (TMO_EN ? 12'h000 : 12'h041)) begin
            miscompares++;
            $display("FAIL timeout_long: got %h want %h", preview,
                     TMO_EN ? 12'h000 : 12'h041);
        end
        step(0, 0, 0, 1, 0, 0);
    endtask

    task automatic test_random();
        int r;
        for (int i = 0; i < 600; i++) begin
            r = int'($urandom_range(0, 15));
            step(($urandom_range(0, 63) == 0),
                 (r <= 5) || (r == 8) || (r == 9),
                 4'($urandom_range(0, 10)),
                 (r == 7) || (r == 8),
                 (r == 6) || (r == 9),
                 ($urandom_range(0, 7) == 0));
            vectors++;
            if (obs !== exp_vec()) begin
                miscompares++;
                $display("FAIL random[%0d]: got %h want %h", i, obs, exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_load_sequence();
        test_shift_invalid();
        test_bad_start();
        test_zero_and_busy();
        test_abort();
        test_timeout();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
